// File: rtl/downsample_2d_box.sv
// 2-D power-of-two decimator: top-left subsample or rounded box average.
// Valid/ready on both sides, one output register stage.
module downsample_2d_box #(
  parameter int pix_bits   = 8,
  parameter int dec_factor = 2,
  parameter int in_width   = 240,
  parameter int in_height  = 480
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [pix_bits-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [pix_bits-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam int LG    = $clog2(dec_factor);
  localparam int HB    = pix_bits + LG;
  localparam int AB    = pix_bits + 2 * LG;
  localparam int OUT_W = in_width / dec_factor;
  localparam int OUT_H = in_height / dec_factor;
  localparam int XW    = (in_width > 1) ? $clog2(in_width) : 1;
  localparam int YW    = (in_height > 1) ? $clog2(in_height) : 1;
  localparam int IW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RND   = (dec_factor * dec_factor) / 2;

  logic [XW-1:0]       x;
  logic [XW-1:0]       x_lo;
  logic [YW-1:0]       y;
  logic [YW-1:0]       y_lo;
  logic [HB-1:0]       hsum;
  logic [HB-1:0]       h_next;
  logic [AB-1:0]       acc [OUT_W];
  logic [AB-1:0]       row;
  logic [AB-1:0]       base;
  logic [AB-1:0]       total;
  logic [IW-1:0]       idx;
  logic [pix_bits-1:0] avg;
  logic                mode_q;
  logic                cur_mode;
  logic                origin;
  logic                x_first;
  logic                x_end;
  logic                y_first;
  logic                y_end;
  logic                last_blk;
  logic                emit;
  logic                accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign x_lo    = x & XW'(dec_factor - 1);
  assign y_lo    = y & YW'(dec_factor - 1);
  assign x_first = (x_lo == '0);
  assign y_first = (y_lo == '0);
  assign x_end   = (x_lo == XW'(dec_factor - 1));
  assign y_end   = (y_lo == YW'(dec_factor - 1));
  assign origin  = (x == '0) && (y == '0);

  // the first pixel of a frame already uses the mode it latches
  assign cur_mode = origin ? mode : mode_q;

  assign last_blk = ((x >> LG) == XW'(OUT_W - 1)) &&
                    ((y >> LG) == YW'(OUT_H - 1));

  assign idx    = IW'(x >> LG);
  assign h_next = (x_first ? '0 : hsum) + HB'(in_data);
  assign row    = AB'(h_next);
  // first row of a block overwrites, so stale entries never leak
  assign base   = y_first ? '0 : acc[idx];
  assign total  = base + row + AB'(RND);
  assign avg    = pix_bits'(total >> (2 * LG));

  assign emit = cur_mode ? (x_end && y_end) : (x_first && y_first);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x      <= '0;
      y      <= '0;
      hsum   <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      hsum <= h_next;
      if (origin) mode_q <= mode;
      if (x == XW'(in_width - 1)) begin
        x <= '0;
        if (y == YW'(in_height - 1)) y <= '0;
        else y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && x_end) acc[idx] <= base + row;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept && emit) begin
      out_valid <= 1'b1;
      out_data  <= cur_mode ? avg : in_data;
      out_last  <= last_blk;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_downsample_2d_box.sv
// Directed bench for downsample_2d_box on an 8x4 frame (dec 2)
// plus a dec 1 pass-through instance.
module tb_downsample_2d_box;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  logic       d1_mode;
  logic [7:0] d1_data;
  logic       d1_valid;
  logic       d1_in_ready;
  logic [7:0] d1_out_data;
  logic       d1_out_valid;
  logic       d1_out_ready;
  logic       d1_out_last;

  initial forever #5 clk = ~clk;

  downsample_2d_box #(
    .pix_bits(8), .dec_factor(2), .in_width(8), .in_height(4)
  ) u0 (
    .clk(clk), .reset(reset), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  downsample_2d_box #(
    .pix_bits(8), .dec_factor(1), .in_width(8), .in_height(4)
  ) u1 (
    .clk(clk), .reset(reset), .mode(d1_mode),
    .in_data(d1_data), .in_valid(d1_valid), .in_ready(d1_in_ready),
    .out_data(d1_out_data), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .out_last(d1_out_last)
  );

  typedef struct {
    logic       m;
    logic [7:0] pix [32];
    logic [7:0] exp [8];
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         c;
  } obs_t;

  vec_t tbl [5];
  obs_t q [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc [32];
  bit   rnd_rdy = 1'b0;

  int bv [8][4] = '{'{1,2,2,2}, '{3,3,3,4}, '{1,1,2,2}, '{0,0,0,1},
                    '{0,1,1,0}, '{255,255,255,254}, '{10,20,30,40},
                    '{7,7,7,7}};
  int e_box [8] = '{5, 7, 9, 11, 21, 23, 25, 27};
  int e_sub [8] = '{0, 2, 4, 6, 16, 18, 20, 22};
  int e_bb  [8] = '{2, 3, 2, 0, 1, 255, 25, 7};
  int e_bs  [8] = '{1, 3, 1, 0, 0, 255, 10, 7};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (reset && out_valid && out_ready)
      q.push_back('{out_data, out_last, cyc});
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic m,
                      input int idx, input int gap);
    bit ok;
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("push_timeout", 0, 1);
    else acc_cyc[idx] = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string nm, input logic [7:0] e [8],
                             input logic m, input bit lat);
    chk({nm, "_count"}, q.size(), 8);
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      int bx;
      int by;
      int src;
      bx  = i % 4;
      by  = i / 4;
      src = m ? (2 * by + 1) * 8 + 2 * bx + 1 : 2 * by * 8 + 2 * bx;
      chk($sformatf("%s_data%0d", nm, i), q[i].d, e[i]);
      chk($sformatf("%s_last%0d", nm, i), q[i].l, (i == 7));
      if (lat) chk($sformatf("%s_lat%0d", nm, i), q[i].c, acc_cyc[src]);
    end
    q.delete();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbl[0].pix[i] = 8'(i);
      tbl[1].pix[i] = 8'(i);
      tbl[2].pix[i] = 8'd255;
    end
    for (int b = 0; b < 8; b++) begin
      int o;
      o = 16 * (b / 4) + 2 * (b % 4);
      tbl[3].pix[o]     = 8'(bv[b][0]);
      tbl[3].pix[o + 1] = 8'(bv[b][1]);
      tbl[3].pix[o + 8] = 8'(bv[b][2]);
      tbl[3].pix[o + 9] = 8'(bv[b][3]);
    end
    tbl[4].pix = tbl[3].pix;
    for (int i = 0; i < 8; i++) begin
      tbl[0].exp[i] = 8'(e_box[i]);
      tbl[1].exp[i] = 8'(e_sub[i]);
      tbl[2].exp[i] = 8'd255;
      tbl[3].exp[i] = 8'(e_bb[i]);
      tbl[4].exp[i] = 8'(e_bs[i]);
    end
    tbl[0].m = 1'b1;
    tbl[1].m = 1'b0;
    tbl[2].m = 1'b1;
    tbl[3].m = 1'b1;
    tbl[4].m = 1'b0;

    reset = 1'b0;
    mode = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    d1_mode = 1'b0;
    d1_data = '0;
    d1_valid = 1'b0;
    d1_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_d1_valid", d1_out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int k = 0; k < 5; k++) begin
      q.delete();
      for (int i = 0; i < 32; i++) push(tbl[k].pix[i], tbl[k].m, i, 0);
      drain(3);
      check_frame($sformatf("vec%0d", k), tbl[k].exp, tbl[k].m, 1'b1);
    end

    q.delete();
    fork
      begin
        for (int i = 0; i < 32; i++) push(8'(i), 1'b1, i, 0);
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!out_valid && n < 100);
        chk("bp_seen", out_valid, 1);
        out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_valid", out_valid, 1);
          chk("bp_data", out_data, 5);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain(3);
    check_frame("bp", tbl[0].exp, 1'b1, 1'b0);

    rnd_rdy = 1'b1;
    for (int i = 0; i < 32; i++)
      push(8'(i), 1'b1, i, int'($urandom_range(0, 1)));
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain(4);
    check_frame("rand", tbl[0].exp, 1'b1, 1'b0);

    for (int i = 0; i < 32; i++) push(8'(i), (i < 10), i, 0);
    drain(3);
    check_frame("msw_a", tbl[0].exp, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) push(8'(i), (i != 0), i, 0);
    drain(3);
    check_frame("msw_b", tbl[1].exp, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) push(8'(i), 1'b1, i, 0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("mid_valid", out_valid, 1);
    chk("mid_data", out_data, 7);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 32; i++) push(8'(i), 1'b1, i, 0);
    drain(3);
    check_frame("post_rst", tbl[0].exp, 1'b1, 1'b1);

    for (int i = 0; i <= 64; i++) begin
      if (i < 64) begin
        d1_data  = 8'(i % 32);
        d1_mode  = (i >= 32);
        d1_valid = 1'b1;
      end else begin
        d1_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("d1_valid%0d", i - 1), d1_out_valid, 1);
        chk($sformatf("d1_data%0d", i - 1), d1_out_data, (i - 1) % 32);
        chk($sformatf("d1_last%0d", i - 1), d1_out_last,
            ((i - 1) % 32) == 31);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("d1_idle", d1_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
